// File: rtl/instr_fetch_unit.sv
// Purpose  : owns PC and IR, runs the IMem read handshake, sequences FETCH -> EXEC -> COMMIT per instruction.
// Latency  : new Opcode/Operand one cycle after ImemAck; strobes sampled in COMMIT, two cycles after the ack.
// Backpress: ImemReq held high until ImemAck; after MAX_WAIT acks missing, stops with FetchErr.
//
// Ports:
//   Clk, reset_n                 clock, synchronous active-low reset
//   ImemReq/ImemAddr             read request (held until ack), address = PC
//   ImemData/ImemAck             instruction word, valid in the ack cycle
//   Opcode/Operand/InstrValid    IR fields to controller; InstrValid pulses in EXEC
//   LoadIR/IncPC/LoadPC/SelPC    controller strobes, sampled in COMMIT
//   RegVal                       register-file jump target
//   PC, Halted, FetchErr         program counter, stopped flag, sticky timeout flag
//   InstrCount                   saturating committed-instruction count
module instr_fetch_unit #(
   parameter int PC_W     = 8,
   parameter int INSTR_W  = 8,
   parameter int MAX_WAIT = 15
) (
   input  logic                 Clk,
   input  logic                 reset_n,
   output logic                 ImemReq,
   output logic [PC_W-1:0]      ImemAddr,
   input  logic [INSTR_W-1:0]   ImemData,
   input  logic                 ImemAck,
   output logic [3:0]           Opcode,
   output logic [INSTR_W-5:0]   Operand,
   output logic                 InstrValid,
   input  logic                 LoadIR,
   input  logic                 IncPC,
   input  logic                 LoadPC,
   input  logic                 SelPC,
   input  logic [PC_W-1:0]      RegVal,
   output logic [PC_W-1:0]      PC,
   output logic                 Halted,
   output logic                 FetchErr,
   output logic [15:0]          InstrCount
);

   localparam int OP_W   = INSTR_W - 4;
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   // Last no-ack cycle that is still tolerated; one more miss is a timeout.
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   typedef enum logic [1:0] {FETCH, EXEC, COMMIT, HALTED} state_t;

   state_t               state, stateNext;
   logic [INSTR_W-1:0]   ir;
   logic [WAIT_W-1:0]    waitCnt, waitNext;
   logic [PC_W-1:0]      pcNext;
   logic [PC_W-1:0]      immTarget;
   logic                 irLoad;
   logic                 errSet;
   logic                 cntInc;

   assign Opcode   = ir[INSTR_W-1 -: 4];
   assign Operand  = ir[INSTR_W-5:0];
   assign ImemAddr = PC;
   // Gated with reset_n so no request is visible while reset is held.
   assign ImemReq  = reset_n && (state == FETCH);

   // Immediate jump target: operand zero-extended, or truncated when wider than PC.
   generate
      if (OP_W >= PC_W) begin : gTrunc
         assign immTarget = Operand[PC_W-1:0];
      end else begin : gExt
         assign immTarget = {{(PC_W-OP_W){1'b0}}, Operand};
      end
   endgenerate

   always_comb begin
      stateNext = state;
      waitNext  = waitCnt;
      pcNext    = PC;
      irLoad    = 1'b0;
      errSet    = 1'b0;
      cntInc    = 1'b0;
      case (state)
         FETCH: begin
            if (ImemAck) begin
               irLoad    = 1'b1;
               waitNext  = '0;
               stateNext = EXEC;
            end else if (waitCnt == WAIT_LAST) begin
               errSet    = 1'b1;
               waitNext  = '0;
               stateNext = HALTED;
            end else begin
               waitNext  = waitCnt + WAIT_W'(1);
            end
         end
         // Gives the controller one cycle to register its strobes against the new Opcode.
         EXEC: stateNext = COMMIT;
         COMMIT: begin
            cntInc = 1'b1;
            if (LoadPC) begin
               pcNext    = SelPC ? immTarget : RegVal;
               stateNext = FETCH;
            end else if (IncPC) begin
               pcNext    = PC + PC_W'(1);
               stateNext = FETCH;
            end else if (LoadIR) begin
               stateNext = FETCH;
            end else begin
               stateNext = HALTED;
            end
         end
         HALTED:  stateNext = HALTED;
         default: stateNext = FETCH;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!reset_n) begin
         state      <= FETCH;
         PC         <= '0;
         ir         <= '0;
         waitCnt    <= '0;
         InstrValid <= 1'b0;
         Halted     <= 1'b0;
         FetchErr   <= 1'b0;
         InstrCount <= '0;
      end else begin
         state      <= stateNext;
         PC         <= pcNext;
         waitCnt    <= waitNext;
         InstrValid <= (stateNext == EXEC);
         Halted     <= (stateNext == HALTED);
         if (irLoad) begin
            ir <= ImemData;
         end
         if (errSet) begin
            FetchErr <= 1'b1;
         end
         if (cntInc && (InstrCount != 16'hFFFF)) begin
            InstrCount <= InstrCount + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose  : directed bench for instr_fetch_unit: table of instructions plus hand-written corner sequences.
// Latency  : inputs driven 1 time unit after posedge, outputs sampled at the same point.
// Backpress: ack delays and timeout are driven explicitly from the table and sequences.
module tb_instr_fetch_unit;

   logic        Clk = 1'b0;
   logic        reset_n;
   logic        ImemReq;
   logic [7:0]  ImemAddr;
   logic [7:0]  ImemData;
   logic        ImemAck;
   logic [3:0]  Opcode;
   logic [3:0]  Operand;
   logic        InstrValid;
   logic        LoadIR, IncPC, LoadPC, SelPC;
   logic [7:0]  RegVal;
   logic [7:0]  PC;
   logic        Halted;
   logic        FetchErr;
   logic [15:0] InstrCount;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit #(.PC_W(8), .INSTR_W(8), .MAX_WAIT(15)) dut (
      .Clk(Clk), .reset_n(reset_n),
      .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemData(ImemData), .ImemAck(ImemAck),
      .Opcode(Opcode), .Operand(Operand), .InstrValid(InstrValid),
      .LoadIR(LoadIR), .IncPC(IncPC), .LoadPC(LoadPC), .SelPC(SelPC), .RegVal(RegVal),
      .PC(PC), .Halted(Halted), .FetchErr(FetchErr), .InstrCount(InstrCount)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [7:0] data;
      int         delay;    // FETCH cycles without ack before the ack cycle
      logic       loadPC;
      logic       incPC;
      logic       loadIR;
      logic       selPC;
      logic [7:0] regVal;
      logic [7:0] expPC;    // PC after COMMIT
   } vec_t;

   vec_t vecs[9];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic clrStrobes();
      LoadIR = 1'b0; IncPC = 1'b0; LoadPC = 1'b0; SelPC = 1'b0; RegVal = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  prevPC;
      logic [15:0] expCnt;

      vecs[0] = '{8'h13, 0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01};
      vecs[1] = '{8'h20, 4,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02};
      vecs[2] = '{8'h79, 0,  1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h09};
      vecs[3] = '{8'h55, 1,  1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5};
      vecs[4] = '{8'h3C, 0,  1'b1, 1'b1, 1'b0, 1'b1, 8'h77, 8'h0C};
      vecs[5] = '{8'h00, 2,  1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h0C};
      vecs[6] = '{8'h4F, 0,  1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF};
      vecs[7] = '{8'h11, 0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00};
      vecs[8] = '{8'h6A, 14, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01};

      // Reset state
      reset_n = 1'b0; ImemAck = 1'b0; ImemData = 8'h00; clrStrobes();
      step(); step();
      chk("rst_ImemReq", 16'(ImemReq), 16'h0);
      chk("rst_PC", 16'(PC), 16'h00);
      chk("rst_Opcode", 16'(Opcode), 16'h0);
      chk("rst_InstrValid", 16'(InstrValid), 16'h0);
      chk("rst_Halted", 16'(Halted), 16'h0);
      chk("rst_FetchErr", 16'(FetchErr), 16'h0);
      chk("rst_InstrCount", InstrCount, 16'h0);
      reset_n = 1'b1;
      #1;
      chk("post_rst_ImemReq", 16'(ImemReq), 16'h1);

      // Table: one full instruction per record, starting in FETCH
      prevPC = 8'h00;
      expCnt = 16'd0;
      for (int v = 0; v < 9; v++) begin
         chk($sformatf("v%0d_fetch_req", v), 16'(ImemReq), 16'h1);
         chk($sformatf("v%0d_fetch_addr", v), 16'(ImemAddr), 16'(prevPC));
         for (int d = 0; d < vecs[v].delay; d++) begin
            ImemAck = 1'b0;
            step();
            chk($sformatf("v%0d_wait%0d_req", v, d), 16'(ImemReq), 16'h1);
            chk($sformatf("v%0d_wait%0d_addr", v, d), 16'(ImemAddr), 16'(prevPC));
            chk($sformatf("v%0d_wait%0d_err", v, d), 16'(FetchErr), 16'h0);
         end
         ImemAck = 1'b1; ImemData = vecs[v].data;
         step();
         // EXEC: new fields one cycle after ack; ack noise here must be ignored
         ImemData = 8'hEE;
         chk($sformatf("v%0d_opcode", v), 16'(Opcode), 16'(vecs[v].data[7:4]));
         chk($sformatf("v%0d_operand", v), 16'(Operand), 16'(vecs[v].data[3:0]));
         chk($sformatf("v%0d_valid", v), 16'(InstrValid), 16'h1);
         chk($sformatf("v%0d_exec_req", v), 16'(ImemReq), 16'h0);
         step();
         // COMMIT: controller drives its strobes
         chk($sformatf("v%0d_commit_valid", v), 16'(InstrValid), 16'h0);
         LoadPC = vecs[v].loadPC; IncPC = vecs[v].incPC; LoadIR = vecs[v].loadIR;
         SelPC = vecs[v].selPC; RegVal = vecs[v].regVal;
         step();
         ImemAck = 1'b0; clrStrobes();
         expCnt = expCnt + 16'd1;
         chk($sformatf("v%0d_pc", v), 16'(PC), 16'(vecs[v].expPC));
         chk($sformatf("v%0d_addr", v), 16'(ImemAddr), 16'(vecs[v].expPC));
         chk($sformatf("v%0d_count", v), InstrCount, expCnt);
         chk($sformatf("v%0d_ir_kept", v), 16'(Opcode), 16'(vecs[v].data[7:4]));
         chk($sformatf("v%0d_halted", v), 16'(Halted), 16'h0);
         prevPC = vecs[v].expPC;
      end

      // HALT: all strobes 0 in COMMIT, then everything frozen
      ImemAck = 1'b1; ImemData = 8'hF0;
      step();
      ImemAck = 1'b0;
      step();
      clrStrobes();
      step();
      chk("halt_halted", 16'(Halted), 16'h1);
      chk("halt_req", 16'(ImemReq), 16'h0);
      chk("halt_count", InstrCount, 16'd10);
      for (int c = 0; c < 20; c++) begin
         ImemAck = 1'($urandom_range(0, 1)); ImemData = 8'($urandom);
         LoadPC = 1'($urandom_range(0, 1)); IncPC = 1'($urandom_range(0, 1));
         LoadIR = 1'($urandom_range(0, 1)); SelPC = 1'($urandom_range(0, 1));
         RegVal = 8'($urandom);
         step();
         chk($sformatf("halt_pc%0d", c), 16'(PC), 16'h01);
      end
      chk("halt_frozen_count", InstrCount, 16'd10);
      chk("halt_frozen_ir", 16'({Opcode, Operand}), 16'hF0);
      chk("halt_frozen_req", 16'(ImemReq), 16'h0);
      chk("halt_still_halted", 16'(Halted), 16'h1);
      ImemAck = 1'b0; clrStrobes();

      // Reset during a FETCH wait, with an ack in the same cycle
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      step(); step(); step();
      reset_n = 1'b0; ImemAck = 1'b1; ImemData = 8'hAB;
      step();
      chk("rstack_ir", 16'({Opcode, Operand}), 16'h00);
      chk("rstack_pc", 16'(PC), 16'h00);
      chk("rstack_valid", 16'(InstrValid), 16'h0);
      chk("rstack_halted", 16'(Halted), 16'h0);
      chk("rstack_err", 16'(FetchErr), 16'h0);
      chk("rstack_count", InstrCount, 16'h0);
      reset_n = 1'b1; ImemAck = 1'b0;
      step();
      chk("resume_addr", 16'(ImemAddr), 16'h00);
      chk("resume_req", 16'(ImemReq), 16'h1);
      ImemAck = 1'b1; ImemData = 8'h25;
      step();
      ImemAck = 1'b0;
      chk("resume_ir", 16'({Opcode, Operand}), 16'h25);
      chk("resume_valid", 16'(InstrValid), 16'h1);
      step();
      IncPC = 1'b1;
      step();
      clrStrobes();
      chk("resume_pc", 16'(PC), 16'h01);

      // Timeout: 14 missed acks tolerated, the 15th stops the unit
      for (int w = 1; w <= 14; w++) begin
         step();
         chk($sformatf("to_wait%0d_err", w), 16'(FetchErr), 16'h0);
         chk($sformatf("to_wait%0d_req", w), 16'(ImemReq), 16'h1);
      end
      step();
      chk("to_err", 16'(FetchErr), 16'h1);
      chk("to_halted", 16'(Halted), 16'h1);
      chk("to_req", 16'(ImemReq), 16'h0);
      ImemAck = 1'b1; ImemData = 8'h99;
      step(); step();
      ImemAck = 1'b0;
      chk("to_err_sticky", 16'(FetchErr), 16'h1);
      chk("to_req_after", 16'(ImemReq), 16'h0);
      chk("to_pc_frozen", 16'(PC), 16'h01);
      chk("to_count", InstrCount, 16'd1);
      reset_n = 1'b0;
      step();
      chk("to_rst_err", 16'(FetchErr), 16'h0);
      chk("to_rst_halted", 16'(Halted), 16'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
